// File: rtl/eth_arb_pkg.sv
// Shared types and defaults for the Ethernet TX arbiter: source indices,
// one-hot FSM states and the default gap/watchdog lengths.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CFG  = 2'd1,
    SRC_CAM0 = 2'd2,
    SRC_CAM1 = 2'd3
  } src_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_BUSY   = 4'b0100,
    ST_GAP    = 4'b1000
  } state_t;

  localparam logic [15:0] GAP_CYCLES_DEF     = 16'd12;
  localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd125000;

  // Pending-vector bit owned by a source: bit0 CFG, bit1 CAM0, bit2 CAM1.
  function automatic logic [2:0] src_mask(src_t s);
    case (s)
      SRC_CFG:  return 3'b001;
      SRC_CAM0: return 3'b010;
      SRC_CAM1: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/eth_tx_rr_pick.sv
// Winner selection: CFG strictly first, cameras alternate via rr_ptr.
// Purely combinational; the arbiter registers the result.
module eth_tx_rr_pick
  import eth_arb_pkg::*;
(
  input  logic [2:0] pend,
  input  src_t       rr_ptr,
  output src_t       winner
);

  // NOTE: assign a default before any branch so every path drives winner and no latch is inferred.
  always_comb begin
    winner = SRC_NONE;
    if (pend[0])                winner = SRC_CFG;
    else if (pend[1] && pend[2]) winner = rr_ptr;
    else if (pend[1])           winner = SRC_CAM0;
    else if (pend[2])           winner = SRC_CAM1;
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one Ethernet/UDP TX core between CFG, CAM0 and CAM1 packet sources.
// Define TX_TIMEOUT_EN to enable the BUSY watchdog (arb_timeout otherwise tied to 0).
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES = GAP_CYCLES_DEF
`ifdef TX_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_tx_start,
  input  logic [31:0] cfg_tx_data,
  input  logic [15:0] cfg_tx_data_num,
  output logic        cfg_tx_req,
  output logic        cfg_tx_done,
  input  logic        cam0_tx_start,
  input  logic [31:0] cam0_tx_data,
  input  logic [15:0] cam0_tx_data_num,
  output logic        cam0_tx_req,
  output logic        cam0_tx_done,
  input  logic        cam1_tx_start,
  input  logic [31:0] cam1_tx_data,
  input  logic [15:0] cam1_tx_data_num,
  output logic        cam1_tx_req,
  output logic        cam1_tx_done,
  output logic        eth_tx_start,
  output logic [31:0] eth_tx_data,
  output logic [15:0] eth_tx_data_num,
  input  logic        eth_tx_req,
  input  logic        eth_tx_done,
  output logic [1:0]  arb_grant,
  output logic        arb_drop,
  output logic        arb_timeout
);

  state_t      state;
  src_t        grant;
  src_t        rr_ptr;
  src_t        winner;
  logic [2:0]  pend;
  logic [2:0]  start_vec;
  logic [2:0]  pend_clr;
  logic [15:0] gap_cnt;
  logic [15:0] win_num;
  logic        busy;
  logic        to_hit;

  eth_tx_rr_pick u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  assign start_vec = {cam1_tx_start, cam0_tx_start, cfg_tx_start};
  assign busy      = (state == ST_BUSY);
  assign arb_grant = grant;
  // A start that lands on the very edge its pend bit is consumed re-queues rather than drops.
  assign pend_clr  = (state == ST_IDLE) ? src_mask(winner) : 3'b000;

  assign cfg_tx_req   = busy & eth_tx_req  & (grant == SRC_CFG);
  assign cfg_tx_done  = busy & eth_tx_done & (grant == SRC_CFG);
  assign cam0_tx_req  = busy & eth_tx_req  & (grant == SRC_CAM0);
  assign cam0_tx_done = busy & eth_tx_done & (grant == SRC_CAM0);
  assign cam1_tx_req  = busy & eth_tx_req  & (grant == SRC_CAM1);
  assign cam1_tx_done = busy & eth_tx_done & (grant == SRC_CAM1);

  always_comb begin
    eth_tx_data = 32'd0;
    win_num     = 16'd0;
    case (grant)
      SRC_CFG:  eth_tx_data = cfg_tx_data;
      SRC_CAM0: eth_tx_data = cam0_tx_data;
      SRC_CAM1: eth_tx_data = cam1_tx_data;
      default:  eth_tx_data = 32'd0;
    endcase
    case (winner)
      SRC_CFG:  win_num = cfg_tx_data_num;
      SRC_CAM0: win_num = cam0_tx_data_num;
      SRC_CAM1: win_num = cam1_tx_data_num;
      default:  win_num = 16'd0;
    endcase
  end

`ifdef TX_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Holds the index of the current BUSY cycle, starting at 1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              to_cnt <= 32'd0;
    else if (state == ST_LAUNCH) to_cnt <= 32'd1;
    else if (busy)               to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit      = (to_cnt == TIMEOUT_CYCLES);
  assign arb_timeout = busy & to_hit & ~eth_tx_done;
`else
  assign to_hit      = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      grant           <= SRC_NONE;
      rr_ptr          <= SRC_CAM0;
      pend            <= 3'b000;
      gap_cnt         <= 16'd0;
      eth_tx_start    <= 1'b0;
      eth_tx_data_num <= 16'd0;
      arb_drop        <= 1'b0;
    end else begin
      pend         <= (pend & ~pend_clr) | start_vec;
      arb_drop     <= |(start_vec & pend & ~pend_clr);
      eth_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (winner != SRC_NONE) begin
            grant           <= winner;
            eth_tx_start    <= 1'b1;
            eth_tx_data_num <= win_num;
            state           <= ST_LAUNCH;
            if (winner == SRC_CAM0)      rr_ptr <= SRC_CAM1;
            else if (winner == SRC_CAM1) rr_ptr <= SRC_CAM0;
          end
        end
        ST_LAUNCH: state <= ST_BUSY;
        ST_BUSY: begin
          if (eth_tx_done || to_hit) begin
            gap_cnt <= 16'd0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (GAP_CYCLES == 16'd0 || gap_cnt == GAP_CYCLES - 16'd1) begin
            grant <= SRC_NONE;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          grant <= SRC_NONE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: launch timing, priority, round-robin,
// drop/queue handling, watchdog (with TX_TIMEOUT_EN) and mid-packet reset.
module tb_eth_tx_arbiter;

  localparam logic [31:0] CFG_DATA  = 32'hC0F6_0017;
  localparam logic [31:0] CAM0_DATA = 32'hCA00_0064;
  localparam logic [31:0] CAM1_DATA = 32'hCA01_00C8;
  localparam logic [15:0] CFG_NUM   = 16'd17;
  localparam logic [15:0] CAM0_NUM  = 16'd100;
  localparam logic [15:0] CAM1_NUM  = 16'd200;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_tx_start = 1'b0, cam0_tx_start = 1'b0, cam1_tx_start = 1'b0;
  logic [31:0] cfg_tx_data = CFG_DATA, cam0_tx_data = CAM0_DATA, cam1_tx_data = CAM1_DATA;
  logic [15:0] cfg_tx_data_num = CFG_NUM, cam0_tx_data_num = CAM0_NUM, cam1_tx_data_num = CAM1_NUM;
  logic        cfg_tx_req, cfg_tx_done, cam0_tx_req, cam0_tx_done, cam1_tx_req, cam1_tx_done;
  logic        eth_tx_start;
  logic [31:0] eth_tx_data;
  logic [15:0] eth_tx_data_num;
  logic        eth_tx_req = 1'b0, eth_tx_done = 1'b0;
  logic [1:0]  arb_grant;
  logic        arb_drop, arb_timeout;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  eth_tx_arbiter #(
    .GAP_CYCLES(16'd12)
`ifdef TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(32'd100)
`endif
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .cfg_tx_start     (cfg_tx_start),
    .cfg_tx_data      (cfg_tx_data),
    .cfg_tx_data_num  (cfg_tx_data_num),
    .cfg_tx_req       (cfg_tx_req),
    .cfg_tx_done      (cfg_tx_done),
    .cam0_tx_start    (cam0_tx_start),
    .cam0_tx_data     (cam0_tx_data),
    .cam0_tx_data_num (cam0_tx_data_num),
    .cam0_tx_req      (cam0_tx_req),
    .cam0_tx_done     (cam0_tx_done),
    .cam1_tx_start    (cam1_tx_start),
    .cam1_tx_data     (cam1_tx_data),
    .cam1_tx_data_num (cam1_tx_data_num),
    .cam1_tx_req      (cam1_tx_req),
    .cam1_tx_done     (cam1_tx_done),
    .eth_tx_start     (eth_tx_start),
    .eth_tx_data      (eth_tx_data),
    .eth_tx_data_num  (eth_tx_data_num),
    .eth_tx_req       (eth_tx_req),
    .eth_tx_done      (eth_tx_done),
    .arb_grant        (arb_grant),
    .arb_drop         (arb_drop),
    .arb_timeout      (arb_timeout)
  );

  always @(negedge sys_clk) if (arb_drop) drop_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] exp_num(logic [1:0] g);
    case (g)
      2'd1:    return CFG_NUM;
      2'd2:    return CAM0_NUM;
      2'd3:    return CAM1_NUM;
      default: return 16'd0;
    endcase
  endfunction

  // Done outputs packed as {cam1, cam0, cfg}.
  function automatic logic [2:0] exp_done(logic [1:0] g);
    case (g)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns at the negedge of the LAUNCH cycle.
  task automatic wait_launch(output logic [1:0] g, output logic [15:0] num, output bit ok);
    ok = 1'b0; g = 2'd0; num = 16'd0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (eth_tx_start) begin
        ok = 1'b1; g = arb_grant; num = eth_tx_data_num;
        break;
      end
      nxt();
    end
  endtask

  // From LAUNCH: one BUSY cycle, then done; returns at the start of the first GAP cycle.
  task automatic finish_pkt(input logic [1:0] g);
    nxt();
    eth_tx_done = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({cam1_tx_done, cam0_tx_done, cfg_tx_done} !== exp_done(g)) begin
      failures++;
      $display("FAIL done_route grant=%0d got=%b exp=%b", g,
               {cam1_tx_done, cam0_tx_done, cfg_tx_done}, exp_done(g));
    end
    nxt();
    eth_tx_done = 1'b0;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (arb_grant == 2'd0) begin idle = 1'b1; break; end
      nxt();
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL drain grant=%0d exp=0 within 40 cycles", arb_grant);
    end
  endtask

  task automatic no_launch(input int n, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (eth_tx_start || arb_grant != 2'd0) seen = 1'b1;
      nxt();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL %s unexpected launch/grant got=1 exp=0", name);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (eth_tx_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", eth_tx_start); end
    checks++; if (eth_tx_data_num !== 16'd0) begin failures++; $display("FAIL rst_num got=%0d exp=0", eth_tx_data_num); end
    checks++; if (arb_grant !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", arb_grant); end
    checks++; if ({arb_drop, arb_timeout} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {arb_drop, arb_timeout}); end
    checks++; if (eth_tx_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", eth_tx_data); end
    nxt();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_cfg();
    int first = -1;
    logic [1:0] g13 = 2'd3;
    nxt(); cfg_tx_start = 1'b1;
    nxt(); cfg_tx_start = 1'b0;
    @(negedge sys_clk);
    checks++; if (eth_tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b exp=0", eth_tx_start); end
    nxt();
    @(negedge sys_clk);
    checks++; if (eth_tx_start !== 1'b1) begin failures++; $display("FAIL single_start_lat2 got=%b exp=1", eth_tx_start); end
    checks++; if (eth_tx_data_num !== CFG_NUM) begin failures++; $display("FAIL single_num got=%0d exp=17", eth_tx_data_num); end
    checks++; if (arb_grant !== 2'd1) begin failures++; $display("FAIL single_grant got=%0d exp=1", arb_grant); end
    for (int i = 0; i < 5; i++) begin
      nxt(); eth_tx_req = 1'b1;
      @(negedge sys_clk);
      checks++;
      if ({cam1_tx_req, cam0_tx_req, cfg_tx_req} !== 3'b001) begin
        failures++;
        $display("FAIL single_req%0d got=%b exp=001", i, {cam1_tx_req, cam0_tx_req, cfg_tx_req});
      end
    end
    checks++; if (eth_tx_data !== CFG_DATA) begin failures++; $display("FAIL single_data got=%h exp=%h", eth_tx_data, CFG_DATA); end
    nxt(); eth_tx_req = 1'b0; eth_tx_done = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({cam1_tx_done, cam0_tx_done, cfg_tx_done} !== 3'b001) begin
      failures++; $display("FAIL single_done got=%b exp=001", {cam1_tx_done, cam0_tx_done, cfg_tx_done});
    end
    // GAP cycle 1: core strobes must not reach any source.
    nxt(); eth_tx_req = 1'b1; eth_tx_done = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({cfg_tx_req, cfg_tx_done, cam0_tx_req, cam0_tx_done, cam1_tx_req, cam1_tx_done} !== 6'd0) begin
      failures++; $display("FAIL gap_ignore got=%b exp=000000",
                           {cfg_tx_req, cfg_tx_done, cam0_tx_req, cam0_tx_done, cam1_tx_req, cam1_tx_done});
    end
    for (int c = 2; c <= 30; c++) begin
      nxt();
      eth_tx_req = 1'b0; eth_tx_done = 1'b0;
      cfg_tx_start = (c == 2);
      @(negedge sys_clk);
      if (c == 13) g13 = arb_grant;
      if (eth_tx_start) begin first = c; break; end
    end
    checks++; if (g13 !== 2'd0) begin failures++; $display("FAIL gap_idle_grant got=%0d exp=0", g13); end
    checks++; if (first != 14) begin failures++; $display("FAIL gap_relaunch_cycle got=%0d exp=14", first); end
    finish_pkt(2'd1);
    drain();
  endtask

  task automatic test_priority();
    logic [1:0] g; logic [15:0] num; bit ok;
    logic [1:0] exp_g [3] = '{2'd1, 2'd2, 2'd3};
    nxt(); cfg_tx_start = 1'b1; cam0_tx_start = 1'b1; cam1_tx_start = 1'b1;
    nxt(); cfg_tx_start = 1'b0; cam0_tx_start = 1'b0; cam1_tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_launch(g, num, ok);
      checks++;
      if (!ok || g !== exp_g[i] || num !== exp_num(exp_g[i])) begin
        failures++;
        $display("FAIL prio_%0d ok=%0d grant=%0d num=%0d exp grant=%0d num=%0d",
                 i, ok, g, num, exp_g[i], exp_num(exp_g[i]));
      end
      finish_pkt(g);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [1:0] g; logic [15:0] num; bit ok;
    logic [1:0] exp_g [5] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    nxt(); cam0_tx_start = 1'b1; cam1_tx_start = 1'b1;
    nxt(); cam0_tx_start = 1'b0; cam1_tx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_launch(g, num, ok);
      checks++;
      if (!ok || g !== exp_g[i]) begin
        failures++; $display("FAIL rr_%0d ok=%0d grant=%0d exp=%0d", i, ok, g, exp_g[i]);
      end
      finish_pkt(g);
      if (i < 3) begin
        cam0_tx_start = (g == 2'd2);
        cam1_tx_start = (g == 2'd3);
        nxt();
        cam0_tx_start = 1'b0; cam1_tx_start = 1'b0;
      end
    end
    drain();
  endtask

  task automatic test_drop();
    logic [1:0] g; logic [15:0] num; bit ok;
    int drops0;
    drops0 = drop_cnt;
    nxt(); cfg_tx_start = 1'b1; cam1_tx_start = 1'b1;
    nxt(); cfg_tx_start = 1'b0; cam1_tx_start = 1'b0;
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd1) begin failures++; $display("FAIL drop_first ok=%0d grant=%0d exp=1", ok, g); end
    nxt(); cam1_tx_start = 1'b1;
    nxt(); cam1_tx_start = 1'b0;
    @(negedge sys_clk);
    checks++; if (arb_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", arb_drop); end
    finish_pkt(2'd1);
    wait_launch(g, num, ok);
    checks++;
    if (!ok || g !== 2'd3 || num !== CAM1_NUM) begin
      failures++; $display("FAIL drop_cam1 ok=%0d grant=%0d num=%0d exp grant=3 num=200", ok, g, num);
    end
    finish_pkt(2'd3);
    drain();
    no_launch(30, "drop_single_pkt");
    checks++; if (drop_cnt - drops0 != 1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drop_cnt - drops0); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] g; logic [15:0] num; bit ok;
    nxt(); cam0_tx_start = 1'b1;
    nxt(); cam0_tx_start = 1'b0;
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd2) begin failures++; $display("FAIL queue_first ok=%0d grant=%0d exp=2", ok, g); end
    nxt(); cam0_tx_start = 1'b1;
    nxt(); cam0_tx_start = 1'b0;
    @(negedge sys_clk);
    checks++; if (arb_drop !== 1'b0) begin failures++; $display("FAIL queue_nodrop got=%b exp=0", arb_drop); end
    finish_pkt(2'd2);
    wait_launch(g, num, ok);
    checks++;
    if (!ok || g !== 2'd2 || num !== CAM0_NUM) begin
      failures++; $display("FAIL queue_second ok=%0d grant=%0d num=%0d exp grant=2 num=100", ok, g, num);
    end
    finish_pkt(2'd2);
    drain();
  endtask

`ifdef TX_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] g; logic [15:0] num; bit ok;
    int hit = -1;
    bit saw_done = 1'b0;
    nxt(); cam0_tx_start = 1'b1;
    nxt(); cam0_tx_start = 1'b0;
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd2) begin failures++; $display("FAIL to_launch ok=%0d grant=%0d exp=2", ok, g); end
    for (int n = 1; n <= 150; n++) begin
      nxt();
      cam1_tx_start = (n == 1);
      @(negedge sys_clk);
      if (cam0_tx_done) saw_done = 1'b1;
      if (arb_timeout) begin hit = n; break; end
    end
    cam1_tx_start = 1'b0;
    checks++; if (hit != 100) begin failures++; $display("FAIL to_cycle got=%0d exp=100", hit); end
    checks++; if (saw_done) begin failures++; $display("FAIL to_nodone got=1 exp=0"); end
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd3) begin failures++; $display("FAIL to_next ok=%0d grant=%0d exp=3", ok, g); end
    finish_pkt(2'd3);
    drain();
  endtask
`else
  task automatic test_timeout();
    logic [1:0] g; logic [15:0] num; bit ok;
    bit saw_to = 1'b0;
    bit left_busy = 1'b0;
    nxt(); cam0_tx_start = 1'b1;
    nxt(); cam0_tx_start = 1'b0;
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd2) begin failures++; $display("FAIL nto_launch ok=%0d grant=%0d exp=2", ok, g); end
    for (int n = 1; n <= 200; n++) begin
      nxt(); eth_tx_req = 1'b1;
      @(negedge sys_clk);
      if (arb_timeout) saw_to = 1'b1;
      if (!cam0_tx_req) left_busy = 1'b1;
    end
    eth_tx_req = 1'b0;
    checks++; if (saw_to) begin failures++; $display("FAIL nto_pulse got=1 exp=0"); end
    checks++; if (left_busy) begin failures++; $display("FAIL nto_busy_held got=left exp=held"); end
    finish_pkt(2'd2);
    drain();
  endtask
`endif

  task automatic test_reset_busy();
    logic [1:0] g; logic [15:0] num; bit ok;
    nxt(); cfg_tx_start = 1'b1; cam0_tx_start = 1'b1; cam1_tx_start = 1'b1;
    nxt(); cfg_tx_start = 1'b0; cam0_tx_start = 1'b0; cam1_tx_start = 1'b0;
    wait_launch(g, num, ok);
    checks++; if (!ok || g !== 2'd1) begin failures++; $display("FAIL rb_launch ok=%0d grant=%0d exp=1", ok, g); end
    nxt(); eth_tx_req = 1'b1;
    #1;
    checks++; if (cfg_tx_req !== 1'b1) begin failures++; $display("FAIL rb_pre_req got=%b exp=1", cfg_tx_req); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_tx_req, cam0_tx_req, cam1_tx_req, eth_tx_start, arb_drop, arb_timeout} !== 6'd0) begin
      failures++; $display("FAIL rb_ctrl_zero got=%b exp=000000",
                           {cfg_tx_req, cam0_tx_req, cam1_tx_req, eth_tx_start, arb_drop, arb_timeout});
    end
    checks++; if (arb_grant !== 2'd0) begin failures++; $display("FAIL rb_grant got=%0d exp=0", arb_grant); end
    checks++; if (eth_tx_data !== 32'd0) begin failures++; $display("FAIL rb_data got=%h exp=0", eth_tx_data); end
    checks++; if (eth_tx_data_num !== 16'd0) begin failures++; $display("FAIL rb_num got=%0d exp=0", eth_tx_data_num); end
    nxt();
    eth_tx_req = 1'b0;
    sys_rst_n = 1'b1;
    no_launch(40, "rb_pending_lost");
  endtask

  initial begin
    test_reset();
    test_single_cfg();
    test_priority();
    test_round_robin();
    test_drop();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
